// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word-organised memory with configurable wait states,
// byte-lane writes and a two-cycle ERROR response for bad addresses or sizes.
module ahb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                    Hclk,
  input  logic                    Hreset,
  input  logic [ADDR_WIDTH-1:0]   Haddr,
  input  logic [1:0]              Htrans,
  input  logic                    Hwrite,
  input  logic [2:0]              Hsize,
  input  logic [2:0]              Hburst,
  input  logic [DATA_WIDTH-1:0]   HWdata,
  input  logic [DATA_WIDTH/8-1:0] Hstrob,
  input  logic                    Hsel,
  input  logic                    Hready,
  output logic [DATA_WIDTH-1:0]   HRdata,
  output logic                    Hreadyout,
  output logic [1:0]              Hresp
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + AW1'(MEM_DEPTH * BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                  state_r, state_nxt_s;
  logic [WCNT_W-1:0]       wcnt_r, wcnt_nxt_s;
  logic [IDX_W-1:0]        idx_r;
  logic [OFF_W-1:0]        off_r;
  logic [2:0]              size_r;
  logic                    write_r;
  logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

  logic                    acc_s, capture_s, done_s, req_err_s, align_err_s;
  logic [ADDR_WIDTH-1:0]   offset_s;
  logic [BYTES-1:0]        lane_s;
  int                      lane_lo_s, lane_hi_s;
  logic                    unused_s;

  // Hburst and the BUSY/IDLE distinction carry no meaning for this slave.
  assign unused_s = ^{Hburst, Htrans[0]};

  // Address-phase decode: accept condition and error classification.
  always_comb begin
    acc_s       = Hsel & Hready & Htrans[1];
    offset_s    = Haddr - BASE_ADDR;
    align_err_s = 1'b0;
    for (int i = 0; i < OFF_W; i++) begin
      align_err_s = align_err_s | ((i < int'(Hsize)) & Haddr[i]);
    end
    req_err_s = (Haddr < BASE_ADDR) || ({1'b0, Haddr} >= LIMIT) ||
                (Hsize > 3'(OFF_W)) || align_err_s;
  end

  // Next-state logic; a new address phase may be captured in IDLE, ERR2 or
  // the completing DATA cycle (back-to-back without a bubble).
  always_comb begin
    state_nxt_s = state_r;
    wcnt_nxt_s  = wcnt_r;
    done_s      = (state_r == ST_DATA) && (wcnt_r == WCNT_W'(0));
    case (state_r)
      ST_IDLE: capture_s = acc_s;
      ST_ERR2: capture_s = acc_s;
      ST_DATA: capture_s = acc_s & done_s;
      default: capture_s = 1'b0;
    endcase
    if (capture_s) begin
      state_nxt_s = req_err_s ? ST_ERR1 : ST_DATA;
      wcnt_nxt_s  = WCNT_W'(WAIT_STATES);
    end else begin
      case (state_r)
        ST_DATA: begin
          if (done_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            wcnt_nxt_s = wcnt_r - WCNT_W'(1);
          end
        end
        ST_ERR1: state_nxt_s = ST_ERR2;
        ST_ERR2: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, wait counter and pending-transfer registers.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_r <= ST_IDLE;
      wcnt_r  <= WCNT_W'(0);
      idx_r   <= IDX_W'(0);
      off_r   <= OFF_W'(0);
      size_r  <= 3'd0;
      write_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      wcnt_r  <= wcnt_nxt_s;
      if (capture_s) begin
        idx_r   <= IDX_W'(offset_s >> OFF_W);
        off_r   <= Haddr[OFF_W-1:0];
        size_r  <= Hsize;
        write_r <= Hwrite;
      end
    end
  end

  // Byte lanes covered by the pending transfer, little-endian from its offset.
  always_comb begin
    lane_s    = '0;
    lane_lo_s = int'(off_r);
    lane_hi_s = lane_lo_s + (32'sd1 << size_r);
    for (int b = 0; b < BYTES; b++) begin
      lane_s[b] = (b >= lane_lo_s) && (b < lane_hi_s);
    end
  end

  // Memory array: contents survive reset; a write lands only on its completing edge.
  always_ff @(posedge Hclk) begin
    if (!Hreset && done_s && write_r) begin
      for (int b = 0; b < BYTES; b++) begin
        if (Hstrob[b] && lane_s[b]) begin
          mem_r[idx_r][8*b +: 8] <= HWdata[8*b +: 8];
        end
      end
    end
  end

  // Bus responses decoded from the registered state.
  always_comb begin
    Hreadyout = 1'b1;
    Hresp     = 2'b00;
    HRdata    = '0;
    case (state_r)
      ST_DATA: begin
        Hreadyout = done_s;
        if (done_s && !write_r) begin
          HRdata = mem_r[idx_r];
        end else begin
          HRdata = '0;
        end
      end
      ST_ERR1: begin
        Hreadyout = 1'b0;
        Hresp     = 2'b01;
      end
      ST_ERR2: Hresp = 2'b01;
      default: Hreadyout = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomised self-checking bench: two slaves (0 and 2 wait states) on a shared
// AHB-Lite bus, checked against a byte-level reference memory model.
module tb_ahb_mem_slave;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          NBYTES = 1024;

  typedef struct {
    logic [1:0]  trans;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = 32'd0;
  logic [3:0]  hstrob = 4'd0;
  logic        hsel = 1'b0;
  logic        force_lo = 1'b0;
  int          tgt = 0;

  logic        hready, sel0, sel1, ro0, ro1;
  logic [1:0]  resp0, resp1;
  logic [31:0] rdata0, rdata1;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  rdy_hist;
  logic [31:0] last_rdata;
  logic [7:0]  mdl [2][NBYTES];
  xfer_t       tq[$];

  assign sel0   = hsel & (tgt == 0);
  assign sel1   = hsel & (tgt == 1);
  assign hready = force_lo ? 1'b0 : ((tgt == 0) ? ro0 : ro1);

  always #5 clk = ~clk;

  ahb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
    .Hclk(clk), .Hreset(hreset), .Haddr(haddr), .Htrans(htrans), .Hwrite(hwrite),
    .Hsize(hsize), .Hburst(hburst), .HWdata(hwdata), .Hstrob(hstrob), .Hsel(sel0),
    .Hready(hready), .HRdata(rdata0), .Hreadyout(ro0), .Hresp(resp0));

  ahb_mem_slave #(.WAIT_STATES(2)) u_ws2 (
    .Hclk(clk), .Hreset(hreset), .Haddr(haddr), .Htrans(htrans), .Hwrite(hwrite),
    .Hsize(hsize), .Hburst(hburst), .HWdata(hwdata), .Hstrob(hstrob), .Hsel(sel1),
    .Hready(hready), .HRdata(rdata1), .Hreadyout(ro1), .Hresp(resp1));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int t);
    return (t == 1) ? 2 : 0;
  endfunction

  function automatic bit exp_err(input xfer_t x);
    if ((x.addr < BASE) || (x.addr >= BASE + NBYTES)) return 1'b1;
    if (x.size > 3'd2) return 1'b1;
    if ((x.addr % (32'd1 << x.size)) != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input int t, input logic [31:0] a);
    int off = int'((a - BASE) & ~32'd3);
    return {mdl[t][off+3], mdl[t][off+2], mdl[t][off+1], mdl[t][off]};
  endfunction

  task automatic model_write(input int t, input xfer_t x);
    int off = int'((x.addr - BASE) & ~32'd3);
    int lo  = int'(x.addr & 32'd3);
    int n   = 1 << x.size;
    for (int b = 0; b < 4; b++) begin
      if (x.strb[b] && (b >= lo) && (b < lo + n)) mdl[t][off+b] = x.wdata[8*b +: 8];
    end
  endtask

  task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic [3:0] s);
    xfer_t x;
    x.trans = 2'b10; x.wr = wr; x.addr = a; x.size = sz; x.wdata = d; x.strb = s;
    tq.push_back(x);
  endtask

  task automatic rand_burst(input int n);
    for (int i = 0; i < n; i++) begin
      xfer_t x;
      int r = $urandom_range(0, 99);
      x.trans = (r < 8) ? 2'($urandom_range(0, 1)) : ((r < 50) ? 2'b11 : 2'b10);
      x.wr    = 1'($urandom_range(0, 1));
      x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      x.addr  = BASE + 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
      r = $urandom_range(0, 19);
      if (r == 0) x.addr = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) x.addr = BASE + NBYTES + 32'($urandom_range(0, 16));
      x.wdata = $urandom;
      x.strb  = 4'($urandom);
      tq.push_back(x);
    end
  endtask

  // Pipelined master: issues tq back-to-back and checks every data phase.
  task automatic run_q();
    int ai = 0, di = -1, waits = 0, bad = 0, idle_bad = 0, cyc = 0;
    bit e, ro;
    logic [1:0]  rs;
    logic [31:0] rd;
    while ((ai < tq.size()) || (di >= 0)) begin
      if (ai < tq.size()) begin
        hsel = 1'b1; htrans = tq[ai].trans; haddr = tq[ai].addr;
        hwrite = tq[ai].wr; hsize = tq[ai].size; hburst = 3'($urandom);
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      if (di >= 0) begin
        hwdata = tq[di].wdata; hstrob = tq[di].strb;
      end else begin
        hwdata = $urandom; hstrob = 4'($urandom);
      end
      @(negedge clk);
      ro = hready;
      rs = (tgt == 1) ? resp1 : resp0;
      rd = (tgt == 1) ? rdata1 : rdata0;
      if (di < 0) begin
        if (!ro || (rs != 2'b00) || (rd != 32'd0)) idle_bad++;
      end else begin
        e = exp_err(tq[di]);
        rdy_hist = {rdy_hist[6:0], ro};
        if (!ro) begin
          waits++;
          if ((rs != (e ? 2'b01 : 2'b00)) || (rd != 32'd0)) bad++;
        end else begin
          check_eq("resp", 64'(rs), e ? 64'd1 : 64'd0);
          check_eq("waits", 64'(waits), 64'(e ? 1 : ws_of(tgt)));
          if (e || tq[di].wr) begin
            check_eq("rdata_zero", 64'(rd), 64'd0);
          end else begin
            check_eq("rdata", 64'(rd), 64'(model_read(tgt, tq[di].addr)));
            last_rdata = rd;
          end
          if (!e && tq[di].wr) model_write(tgt, tq[di]);
          check_eq("wait_cycle_outputs", 64'(bad), 64'd0);
        end
      end
      @(posedge clk); #1;
      if (ro) begin
        if (ai < tq.size()) begin
          di = tq[ai].trans[1] ? ai : -1;
          ai++;
        end else begin
          di = -1;
        end
        waits = 0; bad = 0;
      end
      cyc++;
      if (cyc > 2000) begin
        check_eq("timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    hsel = 1'b0; htrans = 2'b00;
    check_eq("idle_cycles", 64'(idle_bad), 64'd0);
    tq.delete();
  endtask

  initial begin
    // Reset and idle behaviour
    repeat (2) @(posedge clk);
    #1 hreset = 1'b0;
    @(negedge clk);
    check_eq("rst_ready0", 64'(ro0), 64'd1);
    check_eq("rst_ready2", 64'(ro1), 64'd1);
    check_eq("rst_resp0", 64'(resp0), 64'd0);
    check_eq("rst_resp2", 64'(resp1), 64'd0);
    check_eq("rst_rdata0", 64'(rdata0), 64'd0);
    check_eq("rst_rdata2", 64'(rdata1), 64'd0);
    tgt = 1; hsel = 1'b1; htrans = 2'b00; haddr = BASE;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_hold_ready", 64'(ro1), 64'd1);
      check_eq("idle_hold_resp", 64'(resp1), 64'd0);
    end
    @(posedge clk); #1 hsel = 1'b0;

    // Fill both memories with known data
    for (int t = 0; t < 2; t++) begin
      tgt = t;
      for (int w = 0; w < NBYTES / 4; w++) push(1'b1, BASE + 32'(4 * w), 3'd2, $urandom, 4'hF);
      run_q();
    end

    // Zero-wait write then immediate read
    tgt = 0;
    push(1'b1, 32'h1004, 3'd2, 32'hDEAD_BEEF, 4'hF);
    push(1'b0, 32'h1004, 3'd2, 32'd0, 4'h0);
    run_q();
    check_eq("zero_wait_rd", 64'(last_rdata), 64'hDEAD_BEEF);

    // Byte-lane writes
    push(1'b1, 32'h1008, 3'd2, 32'd0, 4'hF);
    push(1'b1, 32'h100A, 3'd0, 32'h00AB_0000, 4'hF);
    push(1'b0, 32'h1008, 3'd2, 32'd0, 4'h0);
    run_q();
    check_eq("byte_lane", 64'(last_rdata), 64'h00AB_0000);
    push(1'b1, 32'h1008, 3'd1, 32'h0000_1234, 4'b0001);
    push(1'b0, 32'h1008, 3'd2, 32'd0, 4'h0);
    run_q();
    check_eq("half_strobe", 64'(last_rdata), 64'h00AB_0034);

    // Wait states and back-to-back ready pattern
    tgt = 1;
    push(1'b0, 32'h1000, 3'd2, 32'd0, 4'h0);
    push(1'b0, 32'h1004, 3'd2, 32'd0, 4'h0);
    rdy_hist = 8'd0;
    run_q();
    check_eq("b2b_pattern", 64'(rdy_hist[5:0]), 64'b001001);

    // Error responses, then a transfer accepted in the second error cycle
    push(1'b0, 32'h0FFC, 3'd2, 32'd0, 4'h0);
    push(1'b1, 32'h1400, 3'd2, 32'h1111_1111, 4'hF);
    push(1'b1, 32'h1001, 3'd1, 32'hFFFF_FFFF, 4'hF);
    push(1'b0, 32'h1000, 3'd2, 32'd0, 4'h0);
    run_q();

    // External Hready low: request must not be accepted
    force_lo = 1'b1; hsel = 1'b1; htrans = 2'b10; haddr = 32'h1000; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk); #1;
    force_lo = 1'b0; hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check_eq("hready_low_no_acc", 64'(ro1), 64'd1);

    // Reset during the first wait cycle of a write
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h1010; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h5555_AAAA; hstrob = 4'hF; hreset = 1'b1;
    @(negedge clk);
    check_eq("mid_wait_ready", 64'(ro1), 64'd0);
    @(posedge clk); #1 hreset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 64'(ro1), 64'd1);
    check_eq("post_rst_resp", 64'(resp1), 64'd0);
    @(posedge clk); #1;
    push(1'b0, 32'h1010, 3'd2, 32'd0, 4'h0);
    run_q();

    // Randomised traffic on both slaves
    for (int t = 0; t < 2; t++) begin
      tgt = t;
      repeat (5) begin
        rand_burst(40);
        run_q();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
